// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB initiator.
package apb_pkg;

   localparam int unsigned APB_AW = 32;
   localparam int unsigned APB_DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Stall counter width; one bit is kept even when the timeout is disabled.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus signals between an initiator and a completer.
interface apb_if
   import apb_pkg::*;
#(
   parameter int unsigned AW = APB_AW,
   parameter int unsigned DW = APB_DW
) ();

   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY
   );

endinterface

// File: rtl/apb_master.sv
// APB initiator: one valid/ready command becomes one SETUP/ACCESS transfer and one response pulse.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned AW      = APB_AW,
   parameter int unsigned DW      = APB_DW,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   apb_if.master         apb
);

   localparam int unsigned    CW         = cnt_width(TIMEOUT);
   localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0]  CNT_MAX    = '1;
   localparam logic [CW-1:0]  CNT_LAST   = TIMEOUT_EN ? CW'(TIMEOUT - 1) : '0;

   apb_state_e    r_state;
   logic          r_psel;
   logic          r_penable;
   logic          r_pwrite;
   logic [AW-1:0] r_paddr;
   logic [DW-1:0] r_pwdata;
   logic          r_rsp_valid;
   logic [DW-1:0] r_rsp_rdata;
   logic          r_rsp_err;
   logic [CW-1:0] r_cnt;

   apb_state_e    w_state_nxt;
   logic          w_psel_nxt;
   logic          w_penable_nxt;
   logic          w_pwrite_nxt;
   logic [AW-1:0] w_paddr_nxt;
   logic [DW-1:0] w_pwdata_nxt;
   logic          w_rsp_valid_nxt;
   logic [DW-1:0] w_rsp_rdata_nxt;
   logic          w_rsp_err_nxt;
   logic          w_cnt_clr;
   logic          w_cnt_inc;
   logic          w_timeout;

   // This stall cycle would be the TIMEOUT-th one; PREADY high still wins.
   assign w_timeout = TIMEOUT_EN && (r_cnt == CNT_LAST);

   // Next state and next registered outputs.
   always_comb begin
      w_state_nxt     = r_state;
      w_psel_nxt      = r_psel;
      w_penable_nxt   = r_penable;
      w_pwrite_nxt    = r_pwrite;
      w_paddr_nxt     = r_paddr;
      w_pwdata_nxt    = r_pwdata;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      w_cnt_clr       = 1'b0;
      w_cnt_inc       = 1'b0;

      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_pwrite_nxt  = cmd_write;
               w_paddr_nxt   = cmd_addr;
               w_pwdata_nxt  = cmd_wdata;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_state_nxt   = SETUP;
            end
         end
         SETUP: begin
            w_penable_nxt = 1'b1;
            w_cnt_clr     = 1'b1;
            w_state_nxt   = ACCESS;
         end
         ACCESS: begin
            if (apb.PREADY) begin
               w_psel_nxt      = 1'b0;
               w_penable_nxt   = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b0;
               w_rsp_rdata_nxt = r_pwrite ? '0 : apb.PRDATA;
               w_state_nxt     = IDLE;
            end else if (w_timeout) begin
               w_psel_nxt      = 1'b0;
               w_penable_nxt   = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_rdata_nxt = '0;
               w_state_nxt     = IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         default: begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            w_state_nxt   = IDLE;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state     <= IDLE;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_psel      <= w_psel_nxt;
         r_penable   <= w_penable_nxt;
         r_pwrite    <= w_pwrite_nxt;
         r_paddr     <= w_paddr_nxt;
         r_pwdata    <= w_pwdata_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   // Saturating count of ACCESS cycles with PREADY low.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_cnt <= '0;
      end else if (w_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign cmd_ready   = (r_state == IDLE);
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign apb.PSEL    = r_psel;
   assign apb.PENABLE = r_penable;
   assign apb.PWRITE  = r_pwrite;
   assign apb.PADDR   = r_paddr;
   assign apb.PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a response scoreboard.
module tb_apb_master;

   localparam int unsigned AW      = 32;
   localparam int unsigned DW      = 32;
   localparam int unsigned TIMEOUT = 4;

   logic          PCLK;
   logic          PRESETn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   apb_if #(.AW(AW), .DW(DW)) bus ();

   apb_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .apb       (bus)
   );

   int checks     = 0;
   int errors     = 0;
   int rsp_seen   = 0;
   int rsp_pushed = 0;
   int cyc        = 0;
   int t_a        = 0;
   logic [DW:0] exp_q[$];

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
   endtask

   task automatic expect_rsp(input logic err, input logic [DW-1:0] rdata);
      exp_q.push_back({err, rdata});
      rsp_pushed++;
   endtask

   // Scoreboard: every response pulse must match the oldest expectation.
   always @(negedge PCLK) begin
      if (rsp_valid === 1'b1) begin
         logic [DW:0] e;
         rsp_seen++;
         chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_err", 64'(rsp_err), 64'(e[DW]));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
         end
      end
   end

   initial begin
      PRESETn     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = '0;
      cmd_wdata   = '0;
      bus.PREADY  = 1'b0;
      bus.PRDATA  = '0;

      // Reset held for three cycles.
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_psel", 64'(bus.PSEL), 64'd0);
      chk("rst_penable", 64'(bus.PENABLE), 64'd0);
      chk("rst_pwrite", 64'(bus.PWRITE), 64'd0);
      chk("rst_paddr", 64'(bus.PADDR), 64'd0);
      chk("rst_pwdata", 64'(bus.PWDATA), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      PRESETn = 1'b1;
      tick();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // Zero-wait write.
      bus.PREADY = 1'b1;
      send(1'b1, 32'hffff_0f0f, 32'd201);
      expect_rsp(1'b0, 32'd0);
      tick();
      cmd_valid = 1'b0;
      chk("wr_setup_psel", 64'(bus.PSEL), 64'd1);
      chk("wr_setup_penable", 64'(bus.PENABLE), 64'd0);
      chk("wr_setup_pwrite", 64'(bus.PWRITE), 64'd1);
      chk("wr_setup_paddr", 64'(bus.PADDR), 64'hffff_0f0f);
      chk("wr_setup_pwdata", 64'(bus.PWDATA), 64'd201);
      chk("wr_setup_ready", 64'(cmd_ready), 64'd0);
      tick();
      chk("wr_access_psel", 64'(bus.PSEL), 64'd1);
      chk("wr_access_penable", 64'(bus.PENABLE), 64'd1);
      tick();
      chk("wr_done_psel", 64'(bus.PSEL), 64'd0);
      chk("wr_done_penable", 64'(bus.PENABLE), 64'd0);
      chk("wr_done_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("wr_done_ready", 64'(cmd_ready), 64'd1);
      tick();
      chk("wr_rsp_pulse", 64'(rsp_valid), 64'd0);
      chk("wr_paddr_hold", 64'(bus.PADDR), 64'hffff_0f0f);

      // Read with three wait states.
      bus.PREADY = 1'b0;
      send(1'b0, 32'hf0f0_ffff, 32'hdead_beef);
      expect_rsp(1'b0, 32'd201);
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("rd_wait_psel", 64'(bus.PSEL), 64'd1);
         chk("rd_wait_penable", 64'(bus.PENABLE), 64'd1);
         chk("rd_wait_paddr", 64'(bus.PADDR), 64'hf0f0_ffff);
         chk("rd_wait_pwrite", 64'(bus.PWRITE), 64'd0);
         tick();
      end
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'd201;
      tick();
      bus.PREADY = 1'b0;
      bus.PRDATA = '0;
      chk("rd_done_psel", 64'(bus.PSEL), 64'd0);
      chk("rd_done_rsp_valid", 64'(rsp_valid), 64'd1);

      // Timeout abort with PREADY held low.
      send(1'b1, 32'h0000_1000, 32'h1111_2222);
      expect_rsp(1'b1, 32'd0);
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("to_wait_psel", 64'(bus.PSEL), 64'd1);
         chk("to_wait_penable", 64'(bus.PENABLE), 64'd1);
         tick();
      end
      chk("to_abort_psel", 64'(bus.PSEL), 64'd0);
      chk("to_abort_penable", 64'(bus.PENABLE), 64'd0);
      chk("to_abort_ready", 64'(cmd_ready), 64'd1);
      tick();
      chk("to_err_hold", 64'(rsp_err), 64'd1);

      // PREADY on the last allowed stall cycle completes; PREADY in SETUP is ignored.
      send(1'b0, 32'h0000_2000, 32'd0);
      expect_rsp(1'b0, 32'h0000_0055);
      tick();
      cmd_valid  = 1'b0;
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h0000_00aa;
      tick();
      chk("edge_setup_ignored_psel", 64'(bus.PSEL), 64'd1);
      chk("edge_setup_ignored_penable", 64'(bus.PENABLE), 64'd1);
      bus.PREADY = 1'b0;
      repeat (3) tick();
      chk("edge_still_busy", 64'(bus.PSEL), 64'd1);
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h0000_0055;
      tick();
      chk("edge_done_psel", 64'(bus.PSEL), 64'd0);

      // Back-to-back with cmd_valid held; fields change after the first accept.
      bus.PRDATA = 32'h1234_5678;
      send(1'b1, 32'h0000_0100, 32'h0000_aaaa);
      expect_rsp(1'b0, 32'd0);
      expect_rsp(1'b0, 32'h1234_5678);
      tick();
      t_a = cyc;
      chk("b2b_a_paddr", 64'(bus.PADDR), 64'h100);
      send(1'b0, 32'h0000_0200, 32'h0000_bbbb);
      tick();
      chk("b2b_a_paddr_stable", 64'(bus.PADDR), 64'h100);
      chk("b2b_a_pwrite_stable", 64'(bus.PWRITE), 64'd1);
      tick();
      chk("b2b_a_done_psel", 64'(bus.PSEL), 64'd0);
      chk("b2b_rsp_cycle_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      chk("b2b_b_psel", 64'(bus.PSEL), 64'd1);
      chk("b2b_b_paddr", 64'(bus.PADDR), 64'h200);
      chk("b2b_b_pwrite", 64'(bus.PWRITE), 64'd0);
      chk("b2b_spacing", 64'(cyc - t_a), 64'd3);
      tick();
      tick();
      chk("b2b_b_done_psel", 64'(bus.PSEL), 64'd0);
      tick();

      // Reset during ACCESS: outputs drop immediately and no response appears.
      bus.PREADY = 1'b0;
      send(1'b1, 32'h0000_3000, 32'h3333_3333);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mid_access_penable", 64'(bus.PENABLE), 64'd1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("mid_rst_psel", 64'(bus.PSEL), 64'd0);
      chk("mid_rst_penable", 64'(bus.PENABLE), 64'd0);
      chk("mid_rst_paddr", 64'(bus.PADDR), 64'd0);
      chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
      tick();
      PRESETn = 1'b1;
      tick();
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h0000_0abc;
      send(1'b0, 32'h0000_4000, 32'd0);
      expect_rsp(1'b0, 32'h0000_0abc);
      tick();
      cmd_valid = 1'b0;
      chk("post_rst_psel", 64'(bus.PSEL), 64'd1);
      tick();
      tick();
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
      bus.PREADY = 1'b0;

      repeat (3) tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("rsp_count", 64'(rsp_seen), 64'(rsp_pushed));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
